// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
// Safety stage that sits between the traffic light controller and the lamp drivers.
// Legal lamp patterns are forwarded with one cycle of latency. Any illegal pattern
// latches a fault, and the lamps flash red until fault_clr arrives while no greens
// conflict and no invalid codes are present.
module traffic_conflict_monitor #(
  parameter int BLINK_DIV = 50_000_000,
  parameter int MIN_YEL   = 40_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] north,
  input  logic [1:0] east,
  input  logic [1:0] south,
  input  logic [1:0] west,
  input  logic       fault_clr,
  output logic [7:0] lamp_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;
  localparam logic [1:0] LAMP_INV = 2'b11;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  localparam logic [25:0] MIN_YEL_C  = 26'(MIN_YEL);
  localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);
  localparam logic [25:0] YCNT_MAX   = '1;

  logic [0:0]       state;
  logic [3:0][1:0]  cur;
  logic [3:0][1:0]  prev;
  logic [25:0]      ycnt [4];
  logic [25:0]      blink_cnt;
  logic             blink_phase;
  logic [2:0]       green_cnt;
  logic             any_inv;
  logic             any_skip;
  logic             any_short;
  logic [2:0]       viol_code;
  logic             safe_to_clear;
  logic             clear_now;

  assign cur       = {north, east, south, west};
  assign fault     = (state == ST_FAULT);
  assign clear_now = (state == ST_FAULT) && fault_clr && safe_to_clear;

  // Classify the current inputs against the per-direction history; the lowest code has priority
  always_comb begin
    green_cnt = 3'd0;
    any_inv   = 1'b0;
    any_skip  = 1'b0;
    any_short = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (cur[d] == LAMP_GRN) green_cnt = green_cnt + 3'd1;
      if (cur[d] == LAMP_INV) any_inv = 1'b1;
      if (prev[d] == LAMP_GRN && cur[d] == LAMP_RED) any_skip = 1'b1;
      if (prev[d] == LAMP_YEL && cur[d] == LAMP_RED && ycnt[d] < MIN_YEL_C) any_short = 1'b1;
    end
    safe_to_clear = (green_cnt < 3'd2) && !any_inv;
    viol_code = 3'd0;
    if (green_cnt >= 3'd2) viol_code = 3'd1;
    else if (any_inv)      viol_code = 3'd2;
    else if (any_skip)     viol_code = 3'd3;
    else if (any_short)    viol_code = 3'd4;
  end

  // Track previous lamp code and saturating yellow run length per direction, restarted on fault exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      for (int d = 0; d < 4; d++) ycnt[d] <= '0;
    end else begin
      prev <= cur;
      for (int d = 0; d < 4; d++) begin
        if (clear_now || cur[d] != LAMP_YEL) ycnt[d] <= '0;
        else if (ycnt[d] != YCNT_MAX)        ycnt[d] <= ycnt[d] + 26'd1;
      end
    end
  end

  // RUN/FAULT control: pass-through, fault latching, blink generation and gated clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      lamp_out    <= 8'h00;
      fault_code  <= 3'd0;
      fault_cnt   <= 8'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (viol_code != 3'd0) begin
            state       <= ST_FAULT;
            lamp_out    <= 8'h00;
            fault_code  <= viol_code;
            if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
          end else begin
            lamp_out <= cur;
          end
        end
        default: begin
          if (clear_now) begin
            state      <= ST_RUN;
            lamp_out   <= cur;
            fault_code <= 3'd0;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
            lamp_out    <= blink_phase ? 8'h00 : 8'hFF;
          end else begin
            blink_cnt <= blink_cnt + 26'd1;
            lamp_out  <= blink_phase ? 8'hFF : 8'h00;
          end
        end
      endcase
    end
  end

endmodule
